// File: rtl/ahb_spi_fifo_master.sv
// AHB-Lite SPI master with TX/RX FIFOs, software slave selects and a
// programmable SCLK divider.
// Optional interrupt output is enabled by defining SPI_FIFO_IRQ_EN.

// Single-clock FIFO used for both the TX and RX paths
module ahb_spi_fifo_master_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        empty,
  output logic        full,
  output logic        dropped
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dropped = push & ~do_push;
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since count gates validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module ahb_spi_fifo_master #(
  parameter int NUM_SS     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic              HREADY,
  input  logic [31:0]       HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  input  logic              SPI_MISO_i,
  output logic              SPI_MOSI_o,
  output logic              SPI_CLK_o,
  output logic [NUM_SS-1:0] SPI_SS_o
`ifdef SPI_FIFO_IRQ_EN
  ,
  output logic              SPI_IRQ_o
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [31:0] DIV_MASK = ((32'h1 << DIV_W) - 32'h1) << 16;
`ifdef SPI_FIFO_IRQ_EN
  localparam logic [31:0] IE_MASK = 32'h0000_1800;
`else
  localparam logic [31:0] IE_MASK = 32'h0000_0000;
`endif
  localparam logic [31:0] CTRL_MASK = 32'h0000_071F | DIV_MASK | IE_MASK;

  state_t state, state_nx;

  logic              dp_valid, dp_write;
  logic [2:0]        dp_addr;
  logic [31:0]       ctrl_q;
  logic [NUM_SS-1:0] ss_q;
  logic              tx_ovf, rx_ovf;
  logic              wr_en, rd_en;
  logic              tx_empty, tx_full, tx_drop, tx_pop;
  logic              rx_empty, rx_full, rx_drop, rx_push, rx_pop;
  logic [31:0]       tx_rdata, rx_rdata, status;
  logic              busy;
  logic [4:0]        len_q;
  logic              cpol_q, cpha_q;
  logic [DIV_W-1:0]  div_q, div_cnt;
  logic [5:0]        edge_cnt;
  logic [31:0]       tx_sr, rx_sr, tx_shifted;
  logic              sclk_q, mosi_q;
  logic              tick, last_edge, leading, sample;
  logic              unused_bits;

  assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0]};

  assign wr_en     = dp_valid & dp_write;
  assign rd_en     = dp_valid & ~dp_write;
  assign rx_pop    = rd_en && (dp_addr == 3'd3);
  assign status    = {25'b0, rx_ovf, tx_ovf, busy, tx_full, tx_empty, rx_full, ~rx_empty};
  assign HREADYOUT = 1'b1;
  assign SPI_SS_o  = ~ss_q;
  assign SPI_CLK_o = sclk_q;
  assign SPI_MOSI_o = mosi_q;

  // Capture the address phase so the data phase can act on HWDATA
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
    end else begin
      dp_valid <= HSEL & HTRANS[1] & HREADY;
      dp_write <= HWRITE;
      dp_addr  <= HADDR[4:2];
    end
  end

  // Software-visible registers and sticky overflow flags (set beats clear)
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl_q <= '0;
      ss_q   <= '0;
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (wr_en && dp_addr == 3'd0) ctrl_q <= HWDATA & CTRL_MASK;
      if (wr_en && dp_addr == 3'd1) ss_q <= HWDATA[NUM_SS-1:0];
      if (tx_drop) tx_ovf <= 1'b1;
      else if (wr_en && dp_addr == 3'd4 && HWDATA[5]) tx_ovf <= 1'b0;
      if (rx_drop) rx_ovf <= 1'b1;
      else if (wr_en && dp_addr == 3'd4 && HWDATA[6]) rx_ovf <= 1'b0;
    end
  end

  // Read data is driven combinationally during the data phase
  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      case (dp_addr)
        3'd0: HRDATA = ctrl_q;
        3'd1: HRDATA[NUM_SS-1:0] = ss_q;
        3'd3: HRDATA = rx_empty ? 32'h0 : rx_rdata;
        3'd4: HRDATA = status;
        default: HRDATA = '0;
      endcase
    end
  end

  ahb_spi_fifo_master_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(HCLK), .reset(HRESET), .push(wr_en && dp_addr == 3'd2), .pop(tx_pop),
    .wdata(HWDATA), .rdata(tx_rdata), .empty(tx_empty), .full(tx_full), .dropped(tx_drop)
  );

  ahb_spi_fifo_master_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(HCLK), .reset(HRESET), .push(rx_push), .pop(rx_pop),
    .wdata(rx_sr), .rdata(rx_rdata), .empty(rx_empty), .full(rx_full), .dropped(rx_drop)
  );

  assign tick       = (state == SHIFT) && (div_cnt == div_q);
  assign last_edge  = tick && (edge_cnt == {len_q, 1'b1});
  assign leading    = ~edge_cnt[0];
  assign sample     = leading ^ cpha_q;
  assign tx_shifted = {tx_sr[30:0], 1'b0};

  // Frame state register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; EN is read live so clearing it stops after this frame
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (ctrl_q[10] && !tx_empty) state_nx = LOAD;
      LOAD:  state_nx = SHIFT;
      SHIFT: if (last_edge) state_nx = DONE;
      DONE:  state_nx = (ctrl_q[10] && !tx_empty) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    busy    = (state != IDLE);
    tx_pop  = (state == LOAD);
    rx_push = (state == DONE);
  end

  // Shift engine: latches frame settings in LOAD and runs SCLK in SHIFT
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      len_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          len_q    <= ctrl_q[4:0];
          cpol_q   <= ctrl_q[8];
          cpha_q   <= ctrl_q[9];
          div_q    <= ctrl_q[16 +: DIV_W];
          div_cnt  <= '0;
          edge_cnt <= '0;
          tx_sr    <= tx_rdata;
          rx_sr    <= '0;
          sclk_q   <= ctrl_q[8];
          mosi_q   <= ctrl_q[9] ? 1'b0 : tx_rdata[ctrl_q[4:0]];
        end
        SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + 6'd1;
            sclk_q   <= ~sclk_q;
            if (sample) begin
              rx_sr <= {rx_sr[30:0], SPI_MISO_i};
            end else begin
              tx_sr  <= tx_shifted;
              mosi_q <= cpha_q ? tx_sr[len_q] : tx_shifted[len_q];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: mosi_q <= 1'b0;
      endcase
    end
  end

`ifdef SPI_FIFO_IRQ_EN
  logic irq_q;
  assign SPI_IRQ_o = irq_q;

  // Registered interrupt combining enabled FIFO levels and sticky errors
  always_ff @(posedge HCLK) begin
    if (HRESET) irq_q <= 1'b0;
    else irq_q <= (ctrl_q[12] & ~rx_empty) | (ctrl_q[11] & tx_empty) | tx_ovf | rx_ovf;
  end
`endif
endmodule

// File: doc/ahb_spi_fifo_master.md
AHB_SPI_FIFO_MASTER -- requirements
Module: ahb_spi_fifo_master

Interface
REQ-001 SHALL have parameter NUM_SS, default 8, number of slave-select outputs (1..32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries in each of the TX and RX FIFOs (power of 2, 2..16).
REQ-003 SHALL have parameter DIV_W, default 16, width of the SCLK divider field (1..16).
REQ-004 SHALL have a single clock and a synchronous, active-high reset.
REQ-005 HCLK  input  1  bus and core clock; all logic on its rising edge.
REQ-006 HRESET  input  1  synchronous active-high reset.
REQ-007 AHB-Lite slave inputs: HSEL 1, HREADY 1, HADDR 32, HWRITE 1, HSIZE 3, HTRANS 2, HWDATA 32.
REQ-008 HRDATA  output  32  read data; HREADYOUT  output  1  always 1 (zero wait state).
REQ-009 SPI_MISO_i  input  1; SPI_MOSI_o  output  1; SPI_CLK_o  output  1; SPI_SS_o  output  NUM_SS  active-low selects.

Function
REQ-010 Transfer accepted on HSEL & HTRANS[1] & HREADY; address/write captured, HWDATA used in the following data phase; HSIZE ignored, full word.
REQ-011 Map (HADDR[4:2]): 0x00 CTRL RW, 0x04 SS RW, 0x08 TXDATA WO, 0x0C RXDATA RO, 0x10 STATUS RO/W1C; other offsets read 0, writes ignored.
REQ-012 CTRL: [4:0] LEN = bits per frame - 1; [8] CPOL; [9] CPHA; [10] EN; [16+DIV_W-1:16] DIV.
REQ-013 SS register bit n=1 drives SPI_SS_o[n]=0; selects are software-controlled only.
REQ-014 TXDATA write pushes HWDATA to TX FIFO; if full, data dropped and TX_OVF set.
REQ-015 RXDATA read returns RX FIFO head in data phase and pops at end of that cycle; empty returns 0, no pop.
REQ-016 STATUS: [0] RX_NE, [1] RX_FULL, [2] TX_EMPTY, [3] TX_FULL, [4] BUSY, [5] TX_OVF, [6] RX_OVF; bits 5/6 sticky, cleared by writing 1.
REQ-017 FSM states IDLE, LOAD, SHIFT, DONE; IDLE->LOAD when EN=1 and TX nonempty; LOAD pops TX, latches LEN/CPOL/CPHA/DIV; LOAD->SHIFT next cycle.
REQ-018 SHIFT: SCLK toggles every DIV+1 HCLK cycles (DIV=0: SCLK=HCLK/2); 2*(LEN+1) edges per frame; SHIFT->DONE after last edge.
REQ-019 MOSI MSB-first from bit LEN; CPHA=0: MOSI valid in LOAD, sample MISO on leading edge, shift on trailing; CPHA=1: shift on leading, sample on trailing.
REQ-020 SCLK idles at latched CPOL; MOSI idles 0.
REQ-021 DONE pushes received word right-aligned, upper bits 0, into RX FIFO; if full, word dropped and RX_OVF set; DONE->IDLE, or ->LOAD directly if EN and TX nonempty (back-to-back frames, one idle half-period max).
REQ-022 BUSY=1 in LOAD, SHIFT, DONE.
REQ-023 CTRL writes while BUSY take effect at next LOAD; clearing EN mid-frame completes the current frame, no new frame.
REQ-024 Simultaneous push and pop on one FIFO (including when full) both occur; count unchanged, no overflow flagged.
REQ-025 FIFO pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.

Reset
REQ-026 HRESET=1 at a clock edge: FSM IDLE, both FIFOs empty, CTRL=0, SS=0 (SPI_SS_o all 1), STATUS=0x04, SPI_CLK_o=0, SPI_MOSI_o=0, HRDATA=0.
REQ-027 Reset mid-frame aborts immediately; partial RX word discarded, no RX push.

Configuration
REQ-028 Macro SPI_FIFO_IRQ_EN defined: extra output SPI_IRQ_o (1 bit) and CTRL[12:11] IE_RX/IE_TX; SPI_IRQ_o = (IE_RX & RX_NE) | (IE_TX & TX_EMPTY) | TX_OVF | RX_OVF, registered, reset 0.
REQ-029 Macro undefined: no SPI_IRQ_o port, CTRL[12:11] read 0 and ignore writes.

Verification
REQ-030 Reset: after HRESET pulse -> SPI_SS_o all 1, SPI_CLK_o=0, STATUS read = 0x00000004.
REQ-031 Loopback MISO=MOSI, CTRL=0x0001_0407 (DIV=1, mode 0, LEN=7), SS=0x1, TXDATA=0xA5 -> 8 SCLK periods of 4 HCLK, RXDATA=0x000000A5, RX_NE then 0.
REQ-032 CTRL mode 3, LEN=15, TXDATA=0x1108, slave drives 0x0102 -> MOSI bits 0x1108 MSB-first, SCLK idles 1, RXDATA=0x00000102.
REQ-033 Write FIFO_DEPTH+1 words with EN=0 -> TX_FULL=1, TX_OVF=1; set EN -> exactly FIFO_DEPTH back-to-back frames; W1C 0x20 clears TX_OVF.
REQ-034 Send FIFO_DEPTH+1 frames without reading -> RX_OVF=1, RX_FULL=1, first FIFO_DEPTH words read back in order; HRESET mid-frame -> SCLK idle, no RX push.
REQ-035 With SPI_FIFO_IRQ_EN, IE_RX=1: SPI_IRQ_o rises one cycle after first RX push, falls after RX drained.
